id_ex_stage: RTL and testbench

- Decode-to-execute pipeline stage, directly downstream of the general purpose register file.
- Combines register-file read data with a writeback bypass and detects load-use hazards.
- Issues a one-cycle stall/bubble on a load-use hazard and latches operands and control into the ID/EX pipeline register for the ALU stage.
- Supports branch flush and keeps a saturating load-use stall counter for performance monitoring.

---
 rtl/pipeline_defs.sv | 24 ++
 rtl/hazard_detection_unit.sv | 33 +++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
// Shared widths and control-bundle bit positions for the decode/execute
// pipeline stages.
package pipeline_defs;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_SIZE  = 5;
    localparam int CONTROL_WIDTH = 12;
    localparam int COUNTER_WIDTH = 16;

    localparam logic [ADDRESS_SIZE-1:0] REGISTER_ZERO = '0;

    // Bit positions inside the opaque EX/MEM/WB control bundle
    localparam int CTRL_ALU_OP_LSB  = 0;
    localparam int CTRL_ALU_OP_MSB  = 3;
    localparam int CTRL_ALU_SRC     = 4;
    localparam int CTRL_SHIFT_IMM   = 5;
    localparam int CTRL_MEM_READ    = 6;
    localparam int CTRL_MEM_WRITE   = 7;
    localparam int CTRL_MEM_SIZE_LO = 8;
    localparam int CTRL_MEM_SIZE_HI = 9;
    localparam int CTRL_REG_WRITE   = 10;
    localparam int CTRL_MEM_TO_REG  = 11;

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: a load sitting in EX whose destination is read
// by the instruction in decode forces a one-cycle stall.
module hazard_detection_unit
    import pipeline_defs::*;
#(
    parameter int ADDR_W = ADDRESS_SIZE
) (
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_address_i,
    input  logic [ADDR_W-1:0] id_rt_address_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic [ADDR_W-1:0] ex_dest_address_i,
    input  logic              flush_i,
    output logic              hazard_o,
    output logic              id_stall_o
);

    logic rs_match;
    logic rt_match;
    logic load_in_ex;

    assign rs_match   = id_uses_rs_i && (id_rs_address_i == ex_dest_address_i);
    assign rt_match   = id_uses_rt_i && (id_rt_address_i == ex_dest_address_i);
    assign load_in_ex = ex_valid_i && ex_is_load_i
                        && (ex_dest_address_i != ADDR_W'(REGISTER_ZERO));

    assign hazard_o   = id_valid_i && load_in_ex && (rs_match || rt_match);
    assign id_stall_o = hazard_o && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use bubble insertion,
// branch flush and a saturating load-use stall counter.
module id_ex_stage
    import pipeline_defs::*;
#(
    parameter int DATA_W  = DATA_WIDTH,
    parameter int ADDR_W  = ADDRESS_SIZE,
    parameter int CTRL_W  = CONTROL_WIDTH,
    parameter int COUNT_W = COUNTER_WIDTH
) (
    input  logic               system_clock,
    input  logic               system_reset_n,
    input  logic               id_valid,
    input  logic [ADDR_W-1:0]  id_rs_address,
    input  logic [ADDR_W-1:0]  id_rt_address,
    input  logic [ADDR_W-1:0]  id_dest_address,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_is_load,
    input  logic [DATA_W-1:0]  id_immediate,
    input  logic [CTRL_W-1:0]  id_control,
    input  logic [DATA_W-1:0]  read_data_1,
    input  logic [DATA_W-1:0]  read_data_2,
    input  logic               wb_write_enable,
    input  logic [ADDR_W-1:0]  wb_write_address,
    input  logic [DATA_W-1:0]  wb_write_data,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_operand_a,
    output logic [DATA_W-1:0]  ex_operand_b,
    output logic [DATA_W-1:0]  ex_immediate,
    output logic [ADDR_W-1:0]  ex_dest_address,
    output logic               ex_is_load,
    output logic [CTRL_W-1:0]  ex_control,
    output logic [COUNT_W-1:0] load_use_stall_count
);

    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  op_a_q, op_a_d;
    logic [DATA_W-1:0]  op_b_q, op_b_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic               load_q, load_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic              hazard;
    logic              bypass_a_hit;
    logic              bypass_b_hit;
    logic [DATA_W-1:0] bypass_a;
    logic [DATA_W-1:0] bypass_b;

    // The register file writes on the edge, so a same-cycle write is not
    // yet visible on its read ports; register zero is never bypassed.
    assign bypass_a_hit = wb_write_enable
                          && (wb_write_address == id_rs_address)
                          && (id_rs_address != ADDR_W'(REGISTER_ZERO));
    assign bypass_b_hit = wb_write_enable
                          && (wb_write_address == id_rt_address)
                          && (id_rt_address != ADDR_W'(REGISTER_ZERO));
    assign bypass_a = bypass_a_hit ? wb_write_data : read_data_1;
    assign bypass_b = bypass_b_hit ? wb_write_data : read_data_2;

    hazard_detection_unit #(
        .ADDR_W(ADDR_W)
    ) u_hazard (
        .id_valid_i        (id_valid),
        .id_rs_address_i   (id_rs_address),
        .id_rt_address_i   (id_rt_address),
        .id_uses_rs_i      (id_uses_rs),
        .id_uses_rt_i      (id_uses_rt),
        .ex_valid_i        (valid_q),
        .ex_is_load_i      (load_q),
        .ex_dest_address_i (dest_q),
        .flush_i           (flush),
        .hazard_o          (hazard),
        .id_stall_o        (id_stall)
    );

    always_comb begin
        valid_d = valid_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        imm_d   = imm_q;
        dest_d  = dest_q;
        load_d  = load_q;
        ctrl_d  = ctrl_q;
        count_d = count_q;
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            load_d  = 1'b0;
            dest_d  = '0;
        end else if (hazard) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            load_d  = 1'b0;
            dest_d  = '0;
            if (count_q != {COUNT_W{1'b1}}) begin
                count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            valid_d = id_valid;
            op_a_d  = bypass_a;
            op_b_d  = bypass_b;
            imm_d   = id_immediate;
            ctrl_d  = id_valid ? id_control      : '0;
            load_d  = id_valid ? id_is_load      : 1'b0;
            dest_d  = id_valid ? id_dest_address : '0;
        end
    end

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            valid_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            imm_q   <= '0;
            dest_q  <= '0;
            load_q  <= 1'b0;
            ctrl_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            imm_q   <= imm_d;
            dest_q  <= dest_d;
            load_q  <= load_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
        end
    end

    assign ex_valid             = valid_q;
    assign ex_operand_a         = op_a_q;
    assign ex_operand_b         = op_b_q;
    assign ex_immediate         = imm_q;
    assign ex_dest_address      = dest_q;
    assign ex_is_load           = load_q;
    assign ex_control           = ctrl_q;
    assign load_use_stall_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; a second narrow-counter instance
// exercises stall-counter saturation within a short run.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        uses_rs, uses_rt, is_load;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic [31:0] rd1, rd2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        flush;

    logic        stall, ex_valid, ex_load;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [4:0]  ex_dest;
    logic [11:0] ex_ctrl;
    logic [15:0] count;

    logic        s_stall, s_valid, s_load;
    logic [31:0] s_a, s_b, s_imm;
    logic [4:0]  s_dest;
    logic [11:0] s_ctrl;
    logic [3:0]  s_count;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .system_clock         (clk),
        .system_reset_n       (rst_n),
        .id_valid             (id_valid),
        .id_rs_address        (id_rs),
        .id_rt_address        (id_rt),
        .id_dest_address      (id_dest),
        .id_uses_rs           (uses_rs),
        .id_uses_rt           (uses_rt),
        .id_is_load           (is_load),
        .id_immediate         (imm),
        .id_control           (ctrl),
        .read_data_1          (rd1),
        .read_data_2          (rd2),
        .wb_write_enable      (wbe),
        .wb_write_address     (wba),
        .wb_write_data        (wbd),
        .flush                (flush),
        .id_stall             (stall),
        .ex_valid             (ex_valid),
        .ex_operand_a         (ex_a),
        .ex_operand_b         (ex_b),
        .ex_immediate         (ex_imm),
        .ex_dest_address      (ex_dest),
        .ex_is_load           (ex_load),
        .ex_control           (ex_ctrl),
        .load_use_stall_count (count)
    );

    id_ex_stage #(.COUNT_W(4)) dut_small (
        .system_clock         (clk),
        .system_reset_n       (rst_n),
        .id_valid             (id_valid),
        .id_rs_address        (id_rs),
        .id_rt_address        (id_rt),
        .id_dest_address      (id_dest),
        .id_uses_rs           (uses_rs),
        .id_uses_rt           (uses_rt),
        .id_is_load           (is_load),
        .id_immediate         (imm),
        .id_control           (ctrl),
        .read_data_1          (rd1),
        .read_data_2          (rd2),
        .wb_write_enable      (wbe),
        .wb_write_address     (wba),
        .wb_write_data        (wbd),
        .flush                (flush),
        .id_stall             (s_stall),
        .ex_valid             (s_valid),
        .ex_operand_a         (s_a),
        .ex_operand_b         (s_b),
        .ex_immediate         (s_imm),
        .ex_dest_address      (s_dest),
        .ex_is_load           (s_load),
        .ex_control           (s_ctrl),
        .load_use_stall_count (s_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs,
                             input logic [4:0] rt, input logic [4:0] dst,
                             input logic urs, input logic urt,
                             input logic ld, input logic [11:0] c);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_dest  = dst;
        uses_rs  = urs;
        uses_rt  = urt;
        is_load  = ld;
        ctrl     = c;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 12'h0);
        imm = '0; rd1 = '0; rd2 = '0;
        wbe = 1'b0; wba = '0; wbd = '0; flush = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;

        // Plain pass-through
        set_instr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 12'h0A5);
        rd1 = 32'h11; rd2 = 32'h22; imm = 32'hFFFF_FFF0;
        tick();
        chk("pt_a", ex_a, 32'h11);
        chk("pt_b", ex_b, 32'h22);
        chk("pt_imm", ex_imm, 32'hFFFF_FFF0);
        chk("pt_dest", 32'(ex_dest), 32'd5);
        chk("pt_ctrl", 32'(ex_ctrl), 32'h0A5);
        chk("pt_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_a", ex_a, 32'd0);
        chk("arst_ctrl", 32'(ex_ctrl), 32'd0);
        #1;
        rst_n = 1'b1;
        set_instr(1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 12'h0A5);
        tick();
        chk("idle_valid", 32'(ex_valid), 32'd0);
        chk("idle_ctrl", 32'(ex_ctrl), 32'd0);

        // Writeback bypass on rs and rt, never on register zero
        set_instr(1'b1, 5'd7, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 12'h001);
        rd1 = 32'h0; rd2 = 32'h22;
        wbe = 1'b1; wba = 5'd7; wbd = 32'hDEAD_BEEF;
        tick();
        chk("byp_a", ex_a, 32'hDEAD_BEEF);
        chk("byp_b_nohit", ex_b, 32'h22);
        set_instr(1'b1, 5'd0, 5'd9, 5'd5, 1'b1, 1'b1, 1'b0, 12'h001);
        wba = 5'd0;
        tick();
        chk("byp_r0", ex_a, 32'h0);
        wba = 5'd9;
        #1;
        tick();
        chk("byp_b", ex_b, 32'hDEAD_BEEF);
        wbe = 1'b0;

        // Load into $8 followed by a use of $8
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 12'h003);
        tick();
        chk("ld_is_load", 32'(ex_load), 32'd1);
        set_instr(1'b1, 5'd8, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 12'h0F0);
        rd1 = 32'h55;
        #1;
        chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bub_valid", 32'(ex_valid), 32'd0);
        chk("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
        chk("lu_count", 32'(count), 32'd1);
        chk("lu_stall_clr", 32'(stall), 32'd0);
        tick();
        chk("lu_iss_valid", 32'(ex_valid), 32'd1);
        chk("lu_iss_a", ex_a, 32'h55);
        chk("lu_iss_ctrl", 32'(ex_ctrl), 32'h0F0);
        chk("lu_iss_count", 32'(count), 32'd1);

        // Source compared but not actually used: no stall
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 12'h003);
        tick();
        set_instr(1'b1, 5'd8, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0, 12'h0F0);
        chk("nouse_stall", 32'(stall), 32'd0);
        tick();
        chk("nouse_valid", 32'(ex_valid), 32'd1);

        // Load to $0 never creates a hazard
        set_instr(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 12'h003);
        tick();
        set_instr(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 12'h0F0);
        chk("r0_stall", 32'(stall), 32'd0);

        // Flush beats a pending hazard
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 12'h003);
        tick();
        set_instr(1'b1, 5'd3, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 12'h0F0);
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(ex_valid), 32'd0);
        chk("fl_count", 32'(count), 32'd1);

        // Self-dependent load repeatedly stalls: 20 hazards
        set_instr(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 12'h003);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            tick();
        end
        chk("sat_count16", 32'(count), 32'd21);
        chk("sat_count4", 32'(s_count), 32'd15);
        tick();
        chk("sat_more16", 32'(count), 32'd22);
        chk("sat_more4", 32'(s_count), 32'd15);

        rst_n = 1'b0;
        #1;
        chk("end_rst_count", 32'(count), 32'd0);
        chk("end_rst_stall", 32'(stall), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
